// File: rtl/pipe_addsub.sv
// rtl/pipe_addsub.sv - chunked, carry-registered pipelined adder/subtractor
// Each slot travels as one word; stage k only resolves chunk k, so operand skew and sum deskew collapse into the slot registers.
module pipe_addsub #(
  parameter int SIZE  = 32,
  parameter int CHUNK = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            valid_in,
  input  logic            sub,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE:0]   q,
  output logic            ovf,
  output logic            valid_out
);

  localparam int STAGES  = (SIZE + CHUNK - 1) / CHUNK;
  localparam int LATENCY = STAGES;
  localparam int NP      = (LATENCY > 1) ? LATENCY - 1 : 1;
  localparam logic [SIZE:0] ONE = {{SIZE{1'b0}}, 1'b1};

  // Returns {carry_out, chunk k sum placed at its bit position, other bits zero}.
  function automatic logic [SIZE:0] chunk_add(input logic [SIZE-1:0] x,
                                               input logic [SIZE-1:0] y,
                                               input logic            cin,
                                               input int              k);
    int lo;
    int w;
    logic [SIZE:0] mask;
    logic [SIZE:0] xs;
    logic [SIZE:0] ys;
    logic [SIZE:0] s;
    logic [SIZE:0] s_hi;
    logic [SIZE:0] placed;
    lo     = k * CHUNK;
    w      = (k == STAGES - 1) ? SIZE - lo : CHUNK;
    mask   = (ONE << w) - ONE;
    xs     = ({1'b0, x} >> lo) & mask;
    ys     = ({1'b0, y} >> lo) & mask;
    s      = xs + ys + (cin ? ONE : '0);
    s_hi   = s >> w;
    placed = (s & mask) << lo;
    return {s_hi[0], placed[SIZE-1:0]};
  endfunction

  logic [SIZE-1:0] a_q   [NP];
  logic [SIZE-1:0] a_d   [NP];
  logic [SIZE-1:0] b_q   [NP];
  logic [SIZE-1:0] b_d   [NP];
  logic [SIZE-1:0] s_q   [NP];
  logic [SIZE-1:0] s_d   [NP];
  logic [NP-1:0]   c_q, c_d;
  logic [NP-1:0]   sub_q, sub_d;
  logic [NP-1:0]   v_q, v_d;

  logic [SIZE:0]   q_q, q_d;
  logic            ovf_q, ovf_d;
  logic            valid_q, valid_d;

  logic [SIZE-1:0] b_in;
  logic [SIZE-1:0] ta, tb, ts;
  logic            tc;
  logic [SIZE:0]   r;
  int              km1;

  logic [SIZE-1:0] fa, fb, fs, sum_fin;
  logic            fc, fsub, fv;
  logic [SIZE:0]   r_fin;

  always_comb begin
    b_in  = sub ? ~b : b;
    a_d   = a_q;
    b_d   = b_q;
    s_d   = s_q;
    c_d   = c_q;
    sub_d = sub_q;
    v_d   = v_q;
    ta    = '0;
    tb    = '0;
    ts    = '0;
    tc    = 1'b0;
    r     = '0;
    km1   = 0;

    for (int k = 0; k < STAGES - 1; k++) begin
      km1      = (k == 0) ? 0 : k - 1;
      ta       = (k == 0) ? a        : a_q[km1];
      tb       = (k == 0) ? b_in     : b_q[km1];
      tc       = (k == 0) ? sub      : c_q[km1];
      ts       = (k == 0) ? '0       : s_q[km1];
      r        = chunk_add(ta, tb, tc, k);
      a_d[k]   = ta;
      b_d[k]   = tb;
      s_d[k]   = ts | r[SIZE-1:0];
      c_d[k]   = r[SIZE];
      sub_d[k] = (k == 0) ? sub      : sub_q[km1];
      v_d[k]   = (k == 0) ? valid_in : v_q[km1];
    end
  end

  // Final chunk resolves straight into the output register.
  always_comb begin
    if (STAGES == 1) begin
      fa   = a;
      fb   = b_in;
      fs   = '0;
      fc   = sub;
      fsub = sub;
      fv   = valid_in;
    end else begin
      fa   = a_q[NP-1];
      fb   = b_q[NP-1];
      fs   = s_q[NP-1];
      fc   = c_q[NP-1];
      fsub = sub_q[NP-1];
      fv   = v_q[NP-1];
    end
    r_fin   = chunk_add(fa, fb, fc, STAGES - 1);
    sum_fin = fs | r_fin[SIZE-1:0];

    q_d     = q_q;
    ovf_d   = ovf_q;
    if (fv) begin
      q_d   = {r_fin[SIZE] ^ fsub, sum_fin};
      ovf_d = (fa[SIZE-1] == fb[SIZE-1]) && (sum_fin[SIZE-1] != fa[SIZE-1]);
    end
    valid_d = fv;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NP; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q     <= '0;
      sub_q   <= '0;
      v_q     <= '0;
      q_q     <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (en) begin
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_q     <= c_d;
      sub_q   <= sub_d;
      v_q     <= v_d;
      q_q     <= q_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign q         = q_q;
  assign ovf       = ovf_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// tb/tb_pipe_addsub.sv - self-checking bench for pipe_addsub
// Reference model: arithmetic per operation plus a slot queue STAGES deep.
module tb_pipe_addsub;

  localparam int SIZE   = 8;
  localparam int CHUNK  = 3;
  localparam int STAGES = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, en, valid_in, sub;
  logic [SIZE-1:0]  a, b;
  logic [SIZE:0]    q;
  logic             ovf, valid_out;

  logic             en_w, valid_w, sub_w;
  logic [31:0]      a_w, b_w;
  logic [32:0]      q_w;
  logic             ovf_w, vo_w;

  pipe_addsub #(.SIZE(SIZE), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .valid_in(valid_in), .sub(sub),
    .a(a), .b(b), .q(q), .ovf(ovf), .valid_out(valid_out)
  );

  pipe_addsub #(.SIZE(32), .CHUNK(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en_w), .valid_in(valid_w), .sub(sub_w),
    .a(a_w), .b(b_w), .q(q_w), .ovf(ovf_w), .valid_out(vo_w)
  );

  typedef struct {
    logic          v;
    logic [SIZE:0] q;
    logic          ovf;
  } slot_t;

  slot_t         pipe[$];
  logic [SIZE:0] exp_q;
  logic          exp_ovf, exp_v;
  int            n_pass, n_total;

  function automatic slot_t ref_op(input logic v, input logic s,
                                   input logic [7:0] x, input logic [7:0] y);
    slot_t r;
    int sx, sy, res, d;
    sx = int'($signed(x));
    sy = int'($signed(y));
    r.v = v;
    if (s) begin
      res = sx - sy;
      d   = int'(x) - int'(y);
      r.q = {(x < y), 8'(d)};
    end else begin
      res = sx + sy;
      d   = int'(x) + int'(y);
      r.q = 9'(d);
    end
    r.ovf = (res > 127) || (res < -128);
    return r;
  endfunction

  task automatic model_reset();
    pipe.delete();
    exp_q   = '0;
    exp_ovf = 1'b0;
    exp_v   = 1'b0;
  endtask

  task automatic tick(input logic v, input logic s, input logic [7:0] x, input logic [7:0] y);
    slot_t e;
    en = 1'b1; valid_in = v; sub = s; a = x; b = y;
    @(posedge clk);
    pipe.push_back(ref_op(v, s, x, y));
    exp_v = 1'b0;
    if (pipe.size() == STAGES) begin
      e = pipe.pop_front();
      exp_v = e.v;
      if (e.v) begin
        exp_q   = e.q;
        exp_ovf = e.ovf;
      end
    end
    @(negedge clk);
  endtask

  task automatic stall();
    en = 1'b0;
    valid_in = 1'($urandom); sub = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    n_total++;
    if (q !== 9'h0 || ovf !== 1'b0 || valid_out !== 1'b0)
      $display("FAIL reset_state: got q=%h ovf=%b vo=%b expected 000/0/0", q, ovf, valid_out);
    else n_pass++;
    n_total++;
    if (q_w !== 33'h0 || vo_w !== 1'b0)
      $display("FAIL reset_wide: got q=%h vo=%b expected 0/0", q_w, vo_w);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [7:0] va[5] = '{8'd200, 8'd5, 8'd7, 8'h7F, 8'h80};
    logic [7:0] vb[5] = '{8'd100, 8'd7, 8'd5, 8'h01, 8'h01};
    logic       vs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [8:0] vq[5] = '{9'h12C, 9'h1FE, 9'h002, 9'h080, 9'h07F};
    logic       vo[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, vs[i], va[i], vb[i]);
      n_total++;
      if (valid_out !== 1'b0)
        $display("FAIL directed_early_%0d: got vo=%b expected 0", i, valid_out);
      else n_pass++;
      tick(1'b0, 1'b0, 8'h0, 8'h0);
      tick(1'b0, 1'b0, 8'h0, 8'h0);
      n_total++;
      if (valid_out !== 1'b1 || q !== vq[i] || ovf !== vo[i])
        $display("FAIL directed_%0d: got q=%h ovf=%b vo=%b expected q=%h ovf=%b vo=1",
                 i, q, ovf, valid_out, vq[i], vo[i]);
      else n_pass++;
      tick(1'b0, 1'b0, 8'h0, 8'h0);
      n_total++;
      if (valid_out !== 1'b0 || q !== vq[i] || ovf !== vo[i])
        $display("FAIL directed_hold_%0d: got q=%h ovf=%b vo=%b expected q=%h ovf=%b vo=0",
                 i, q, ovf, valid_out, vq[i], vo[i]);
      else n_pass++;
    end
  endtask

  task automatic test_streaming();
    logic vpat[13] = '{1,1,1,1,1,1,0,1,1,1,0,0,0};
    int pulses;
    pulses = 0;
    for (int i = 0; i < 13; i++) begin
      tick(vpat[i], 1'(i % 2), 8'($urandom), 8'($urandom));
      if (valid_out === 1'b1) pulses++;
      n_total++;
      if (valid_out !== exp_v || q !== exp_q || ovf !== exp_ovf)
        $display("FAIL stream_%0d: got q=%h ovf=%b vo=%b expected q=%h ovf=%b vo=%b",
                 i, q, ovf, valid_out, exp_q, exp_ovf, exp_v);
      else n_pass++;
    end
    n_total++;
    if (pulses != 9)
      $display("FAIL stream_pulses: got %0d expected 9", pulses);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [8:0] fq;
    logic       fo, fv;
    int         pulses;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
    fq = exp_q; fo = exp_ovf; fv = exp_v;
    for (int i = 0; i < 3; i++) begin
      stall();
      n_total++;
      if (valid_out !== fv || q !== fq || ovf !== fo)
        $display("FAIL stall_frozen_%0d: got q=%h ovf=%b vo=%b expected q=%h ovf=%b vo=%b",
                 i, q, ovf, valid_out, fq, fo, fv);
      else n_pass++;
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 8'h0, 8'h0);
      if (valid_out === 1'b1) pulses++;
      n_total++;
      if (valid_out !== exp_v || q !== exp_q || ovf !== exp_ovf)
        $display("FAIL stall_resume_%0d: got q=%h ovf=%b vo=%b expected q=%h ovf=%b vo=%b",
                 i, q, ovf, valid_out, exp_q, exp_ovf, exp_v);
      else n_pass++;
    end
    n_total++;
    if (pulses != 2)
      $display("FAIL stall_pulses: got %0d expected 2", pulses);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 1'b0, 8'hF0, 8'h33);
    tick(1'b1, 1'b1, 8'h10, 8'h20);
    tick(1'b1, 1'b0, 8'h7F, 8'h7F);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (q !== 9'h0 || ovf !== 1'b0 || valid_out !== 1'b0)
      $display("FAIL reset_mid_async: got q=%h ovf=%b vo=%b expected 000/0/0", q, ovf, valid_out);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) tick(1'b1, 1'b1, 8'($urandom), 8'($urandom));
      else tick(1'b0, 1'b0, 8'h0, 8'h0);
      n_total++;
      if (valid_out !== exp_v || q !== exp_q || ovf !== exp_ovf)
        $display("FAIL reset_mid_after_%0d: got q=%h ovf=%b vo=%b expected q=%h ovf=%b vo=%b",
                 i, q, ovf, valid_out, exp_q, exp_ovf, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_wide();
    logic [31:0] wa[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF};
    logic [31:0] wb[3] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
    logic        ws[3] = '{1'b0, 1'b1, 1'b0};
    logic [32:0] wq[3] = '{33'h1_0000_0000, 33'h1_FFFF_FFFF, 33'h0_8000_0000};
    logic        wo[3] = '{1'b0, 1'b0, 1'b1};
    int cnt;
    for (int i = 0; i < 3; i++) begin
      valid_w = 1'b1; sub_w = ws[i]; a_w = wa[i]; b_w = wb[i];
      @(posedge clk);
      @(negedge clk);
      valid_w = 1'b0;
      cnt = 1;
      while (vo_w !== 1'b1 && cnt < 40) begin
        @(posedge clk);
        cnt++;
        @(negedge clk);
      end
      n_total++;
      if (cnt != 32)
        $display("FAIL wide_latency_%0d: got %0d edges expected 32", i, cnt);
      else n_pass++;
      n_total++;
      if (q_w !== wq[i] || ovf_w !== wo[i])
        $display("FAIL wide_result_%0d: got q=%h ovf=%b expected q=%h ovf=%b",
                 i, q_w, ovf_w, wq[i], wo[i]);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; en = 1'b0; valid_in = 1'b0; sub = 1'b0; a = '0; b = '0;
    en_w = 1'b1; valid_w = 1'b0; sub_w = 1'b0; a_w = '0; b_w = '0;
    model_reset();
    test_reset();
    test_directed();
    test_streaming();
    test_stall();
    test_reset_mid();
    test_wide();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
